instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage of the 5-stage pipelined RISC-V core. Drives the PC and requests instructions from a variable-latency instruction memory with a req/ack handshake.
- Provides the IF/ID pipeline register (InstrD, PCD, PCPlus4D, ValidD) to the decode stage.
- Handles decode stalls through a one-entry skid buffer, and handles execute-stage redirects (branches and jumps), including a redirect that arrives while a memory request is in flight.

Parameters:
- PC_W, 16, PC and address width; all PC arithmetic is modulo 2^PC_W.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held high until ack
- imem_addr  out  PC_W  fetch address; stable while imem_req=1 and no ack
- imem_ack  in  1  memory accepted the request; imem_rdata is valid in the same cycle
- imem_rdata  in  INSTR_W  fetched instruction
- StallF  in  1  hazard unit: hold the IF/ID register
- FlushD  in  1  clear the IF/ID register to a bubble
- PCSrcE  in  1  redirect request from execute
- PCTargetE  in  PC_W  redirect target
- InstrD  out  INSTR_W  IF/ID instruction
- PCD  out  PC_W  IF/ID PC
- PCPlus4D  out  PC_W  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (reset=0, asynchronous):
  - PCF=RESET_PC, state=BOOT, imem_req=0, skid empty.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - Any outstanding request is abandoned, and imem_req drops immediately.
- State machine:
  - BOOT: one cycle with imem_req=0, then go to WAIT.
  - WAIT: imem_req=1, imem_addr=PCF.
  - HOLD: fetched word parked in the skid buffer; imem_req=0.
  - DRAIN: redirect pending while a request is in flight.
- WAIT, ack=1, StallF=0, PCSrcE=0:
  - IF/ID <= {rdata, PCF, PCF+4}, ValidD=1.
  - PCF <= PCF+4, stay in WAIT.
  - Back-to-back: imem_req stays 1 with the new address, giving 1 instruction/cycle when ack is constant.
- WAIT, ack=0, StallF=0: IF/ID <= bubble (NOP_INSTR, ValidD=0; PCD and PCPlus4D hold).
- StallF=1 with no flush and no redirect: IF/ID holds.
  - If ack=1 in WAIT, the word and its PC go to the skid buffer, PCF <= PCF+4, state goes to HOLD.
- HOLD, StallF=0: skid contents move into IF/ID (ValidD=1), skid is cleared, state goes to WAIT and requests PCF.
- PCSrcE=1 has the highest priority in every state:
  - PCF <= {PCTargetE[PC_W-1:2],2'b00}.
  - IF/ID <= bubble regardless of StallF; skid is cleared.
  - In WAIT with ack=1 in the same cycle: rdata is discarded, next state is WAIT with the new address.
  - In WAIT with ack=0: state goes to DRAIN.
  - In BOOT or HOLD: state goes to WAIT.
- DRAIN:
  - imem_req=1 and imem_addr hold the old address until ack.
  - On ack, rdata is discarded and state goes to WAIT at the redirected PCF.
  - A further PCSrcE during DRAIN updates the target only.
- FlushD=1 (without PCSrcE): IF/ID <= bubble; it overrides StallF.
  - Fetch continues normally, and a word accepted in this cycle still advances PCF.
  - If ack=1 in WAIT in the same cycle, the word is discarded.
- Wrap-around: PCF=16'hFFFC fetches, then PCF=16'h0000; PCPlus4D=16'h0000.
- imem_ack while imem_req=0 is ignored.

Test Plan:
- Reset low mid-fetch, then release; memory acks every cycle, program 0x00,0x04,0x08 → after BOOT, InstrD tracks the words at successive addresses, PCD=0,4,8, ValidD=1 every cycle.
- Ack latency 3 cycles → imem_addr is stable for 3 cycles; ValidD=0 bubbles between instructions; no instruction is lost or duplicated.
- StallF=1 for 2 cycles coincident with ack of addr 0x08 → IF/ID holds 0x04; after release, IF/ID=0x08 from the skid, then 0x0C; no refetch of 0x08.
- PCSrcE=1 to PCTargetE=0x40 while the request to 0x10 is outstanding (ack 2 cycles later) → DRAIN; the 0x10 word never appears in IF/ID; the next request addr=0x40; IF/ID shows a bubble during the redirect.
- PCSrcE and FlushD together with StallF=1 → IF/ID=NOP_INSTR, ValidD=0; the next valid instruction has PCD=target.
- PCF=0xFFFC with ack → PCD=0xFFFC, PCPlus4D=0x0000, next imem_addr=0x0000; PCTargetE=0x0043 → imem_addr=0x0040.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: IF stage with req/ack imem fetch, IF/ID register, one-entry skid buffer and redirect drain
// Ports: clk, reset (async active-low); imem_req/imem_addr/imem_ack/imem_rdata fetch handshake;
//        StallF/FlushD hazard controls; PCSrcE/PCTargetE execute redirect; InstrD/PCD/PCPlus4D/ValidD IF/ID outputs.
module instr_fetch_unit #(
  parameter int PC_W = 16,
  parameter int INSTR_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               StallF,
  input  logic               FlushD,
  input  logic               PCSrcE,
  input  logic [PC_W-1:0]    PCTargetE,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [PC_W-1:0]    PCPlus4D,
  output logic               ValidD
);
  typedef enum logic [1:0] {S_BOOT, S_WAIT, S_HOLD, S_DRAIN} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, tgt_q, tgt_d, skid_pc_q, skid_pc_d, pcd_q, pcd_d, p4_q, p4_d;
  logic [PC_W-1:0] redir, word_pc;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d, instr_q, instr_d, word;
  logic valid_q, valid_d, ack, have_word, load, bubble;
  // In DRAIN pc_q keeps the in-flight address; the redirect target waits in tgt_q
  assign imem_req = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign imem_addr = pc_q;
  assign ack = imem_ack & imem_req;
  assign redir = PCTargetE & ~PC_W'(3);
  assign InstrD = instr_q;
  assign PCD = pcd_q;
  assign PCPlus4D = p4_q;
  assign ValidD = valid_q;
  always_comb begin
    have_word = (state_q == S_WAIT && ack) || state_q == S_HOLD;
    word = state_q == S_HOLD ? skid_instr_q : imem_rdata;
    word_pc = state_q == S_HOLD ? skid_pc_q : pc_q;
    load = have_word && !PCSrcE && !FlushD && !StallF;
    bubble = !load && (PCSrcE || FlushD || !StallF);
    instr_d = load ? word : bubble ? NOP_INSTR : instr_q;
    valid_d = load || (!bubble && valid_q);
    pcd_d = load ? word_pc : pcd_q;
    p4_d = load ? word_pc + PC_W'(4) : p4_q;
    state_d = state_q;
    pc_d = pc_q;
    tgt_d = tgt_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d = skid_pc_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_WAIT;
        pc_d = PCSrcE ? redir : pc_q;
      end
      S_WAIT: begin
        if (PCSrcE) begin
          state_d = ack ? S_WAIT : S_DRAIN;
          pc_d = ack ? redir : pc_q;
          tgt_d = redir;
        end else if (ack) begin
          pc_d = pc_q + PC_W'(4);
          state_d = (StallF && !FlushD) ? S_HOLD : S_WAIT;
          skid_instr_d = imem_rdata;
          skid_pc_d = pc_q;
        end
      end
      S_HOLD: begin
        pc_d = PCSrcE ? redir : pc_q;
        state_d = (PCSrcE || FlushD || !StallF) ? S_WAIT : S_HOLD;
      end
      S_DRAIN: begin
        tgt_d = PCSrcE ? redir : tgt_q;
        pc_d = ack ? tgt_d : pc_q;
        state_d = ack ? S_WAIT : S_DRAIN;
      end
      default: state_d = S_BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      pc_q <= RESET_PC;
      tgt_q <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q <= '0;
      instr_q <= NOP_INSTR;
      pcd_q <= '0;
      p4_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      tgt_q <= tgt_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q <= skid_pc_d;
      instr_q <= instr_d;
      pcd_q <= pcd_d;
      p4_q <= p4_d;
      valid_q <= valid_d;
    end
  end
endmodule
